// File: rtl/peribus_master.sv
// peribus_master: Peribus initiator bridging the CPU data-memory port to the
// GPIO/timer/UART responders on the shared Peribus.
//
// Every output is a flop. A write acks 2 cycles after cpu_req is sampled,
// a read after 3 cycles and a decode error after 1 cycle. One IDLE cycle
// separates transactions.
//
// Optional build macro: PERIBUS_IRQ_ID_EN. When defined it adds the irq_id
// output and a read-only status register at index 7 that returns irq_id.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   cpu_req/we/addr     CPU request, direction and word address
//                       ([15:8] window, [4:2] peripheral index, [1:0] register)
//   cpu_wdata           CPU write data
//   cpu_ack/err/rdata   completion pulse, decode error, read result
//   cpu_irq             OR of the registered responder irq lines
//   pb_addr/write_data  responder register address and write data
//   pb_write_en/read_en single-cycle strobes
//   pb_chipselect       one-hot responder select
//   pb_read_data        responder read buses, peripheral i at [16*i+15:16*i]
//   pb_irq              responder irq lines
//   irq_id              (PERIBUS_IRQ_ID_EN) lowest pending irq index
module peribus_master #(
  parameter int unsigned NUM_PERIPH = 4,
  parameter logic [7:0]  BASE_HI    = 8'hFF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [15:0]                cpu_addr,
  input  logic [15:0]                cpu_wdata,
  output logic                       cpu_ack,
  output logic                       cpu_err,
  output logic [15:0]                cpu_rdata,
  output logic                       cpu_irq,
  output logic [1:0]                 pb_addr,
  output logic [15:0]                pb_write_data,
  output logic                       pb_write_en,
  output logic                       pb_read_en,
  output logic [NUM_PERIPH-1:0]      pb_chipselect,
  input  logic [16*NUM_PERIPH-1:0]   pb_read_data,
  input  logic [NUM_PERIPH-1:0]      pb_irq
`ifdef PERIBUS_IRQ_ID_EN
  ,
  output logic [2:0]                 irq_id
`endif
);

  localparam logic [3:0] NumPeriphW = 4'(NUM_PERIPH);

  typedef enum logic [1:0] {StIdle, StAccess, StRdwait, StAck} state_e;

  state_e state_q, state_d;

  // Latched transaction attributes.
  logic       we_q, we_d;
  logic [2:0] idx_q, idx_d;

  // Next values of the registered outputs.
  logic                  cpu_ack_d, cpu_err_d;
  logic [15:0]           cpu_rdata_d;
  logic [1:0]            pb_addr_d;
  logic [15:0]           pb_write_data_d;
  logic                  pb_write_en_d, pb_read_en_d;
  logic [NUM_PERIPH-1:0] pb_chipselect_d;
  logic [15:0]           rd_sel;

  // Address decode of the incoming request.
  logic [2:0] req_idx;
  logic       win_hit, periph_hit, reg_hit, dec_ok;
  logic       unused_addr;

  assign req_idx     = cpu_addr[4:2];
  assign win_hit     = (cpu_addr[15:8] == BASE_HI);
  assign unused_addr = ^cpu_addr[7:5];

`ifdef PERIBUS_IRQ_ID_EN
  logic       int_q, int_d;
  logic [2:0] irq_id_d;
  // The status register owns index 7 even if an eighth responder exists.
  assign periph_hit = win_hit && ({1'b0, req_idx} < NumPeriphW) && (req_idx != 3'd7);
  // Status register is read-only; a write there is a decode error.
  assign reg_hit    = win_hit && (req_idx == 3'd7) && !cpu_we;
`else
  assign periph_hit = win_hit && ({1'b0, req_idx} < NumPeriphW);
  assign reg_hit    = 1'b0;
`endif

  assign dec_ok = periph_hit || reg_hit;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cpu_req) state_d = dec_ok ? StAccess : StAck;
      StAccess: state_d = we_q ? StAck : StRdwait;
      StRdwait: state_d = StAck;
      StAck:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Read-data slice of the latched peripheral index.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < int'(NUM_PERIPH); i++) begin
      if (idx_q == 3'(i)) rd_sel = pb_read_data[16*i +: 16];
    end
  end

  // Output logic: next values for the output flops.
  always_comb begin
    we_d            = we_q;
    idx_d           = idx_q;
    cpu_ack_d       = (state_d == StAck);
    cpu_err_d       = 1'b0;
    cpu_rdata_d     = cpu_rdata;
    pb_addr_d       = pb_addr;
    pb_write_data_d = pb_write_data;
    pb_write_en_d   = 1'b0;
    pb_read_en_d    = 1'b0;
    pb_chipselect_d = '0;
`ifdef PERIBUS_IRQ_ID_EN
    int_d           = int_q;
`endif

    if (state_q == StIdle && cpu_req) begin
      we_d      = cpu_we;
      idx_d     = req_idx;
      cpu_err_d = !dec_ok;
`ifdef PERIBUS_IRQ_ID_EN
      int_d     = reg_hit;
`endif
      if (periph_hit) begin
        for (int i = 0; i < int'(NUM_PERIPH); i++) begin
          pb_chipselect_d[i] = (req_idx == 3'(i));
        end
        pb_addr_d = cpu_addr[1:0];
        if (cpu_we) begin
          pb_write_en_d   = 1'b1;
          pb_write_data_d = cpu_wdata;
        end else begin
          pb_read_en_d = 1'b1;
        end
      end
    end

    // Responder registered its data on the ACCESS edge; capture it now.
    if (state_q == StRdwait) begin
`ifdef PERIBUS_IRQ_ID_EN
      cpu_rdata_d = int_q ? {13'b0, irq_id} : rd_sel;
`else
      cpu_rdata_d = rd_sel;
`endif
    end
  end

`ifdef PERIBUS_IRQ_ID_EN
  // Lowest-numbered pending line wins.
  always_comb begin
    irq_id_d = 3'd0;
    for (int i = int'(NUM_PERIPH) - 1; i >= 0; i--) begin
      if (pb_irq[i]) irq_id_d = 3'(i);
    end
  end
`endif

  // Output and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      we_q          <= 1'b0;
      idx_q         <= 3'd0;
      cpu_ack       <= 1'b0;
      cpu_err       <= 1'b0;
      cpu_rdata     <= 16'h0;
      cpu_irq       <= 1'b0;
      pb_addr       <= 2'd0;
      pb_write_data <= 16'h0;
      pb_write_en   <= 1'b0;
      pb_read_en    <= 1'b0;
      pb_chipselect <= '0;
`ifdef PERIBUS_IRQ_ID_EN
      int_q         <= 1'b0;
      irq_id        <= 3'd0;
`endif
    end else begin
      we_q          <= we_d;
      idx_q         <= idx_d;
      cpu_ack       <= cpu_ack_d;
      cpu_err       <= cpu_err_d;
      cpu_rdata     <= cpu_rdata_d;
      cpu_irq       <= |pb_irq;
      pb_addr       <= pb_addr_d;
      pb_write_data <= pb_write_data_d;
      pb_write_en   <= pb_write_en_d;
      pb_read_en    <= pb_read_en_d;
      pb_chipselect <= pb_chipselect_d;
`ifdef PERIBUS_IRQ_ID_EN
      int_q         <= int_d;
      irq_id        <= irq_id_d;
`endif
    end
  end

endmodule

// File: tb/tb_peribus_master.sv
// tb_peribus_master: directed self-checking bench for peribus_master
// (NUM_PERIPH = 4, BASE_HI = 8'hFF). Inputs change 1 time unit after a
// rising edge and outputs are sampled at the same point.
module tb_peribus_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, cpu_err, cpu_irq;
  logic [15:0] cpu_rdata;
  logic [1:0]  pb_addr;
  logic [15:0] pb_write_data;
  logic        pb_write_en, pb_read_en;
  logic [3:0]  pb_chipselect;
  logic [63:0] pb_read_data = '0;
  logic [3:0]  pb_irq;
`ifdef PERIBUS_IRQ_ID_EN
  logic [2:0]  irq_id;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;
  int strobe_cnt = 0;
  int cs_cnt = 0;
  int snap_ack, snap_strobe, snap_cs;

  peribus_master #(
    .NUM_PERIPH(4),
    .BASE_HI   (8'hFF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_err      (cpu_err),
    .cpu_rdata    (cpu_rdata),
    .cpu_irq      (cpu_irq),
    .pb_addr      (pb_addr),
    .pb_write_data(pb_write_data),
    .pb_write_en  (pb_write_en),
    .pb_read_en   (pb_read_en),
    .pb_chipselect(pb_chipselect),
    .pb_read_data (pb_read_data),
    .pb_irq       (pb_irq)
`ifdef PERIBUS_IRQ_ID_EN
    ,
    .irq_id       (irq_id)
`endif
  );

  always #5 clock = ~clock;

  // Responders register a fixed value on the edge that sees their read strobe.
  always @(posedge clock) begin
    if (pb_read_en && pb_chipselect[0]) pb_read_data[15:0]  <= 16'hA5A5;
    if (pb_read_en && pb_chipselect[1]) pb_read_data[31:16] <= 16'h1111;
    if (pb_read_en && pb_chipselect[2]) pb_read_data[47:32] <= 16'h2222;
    if (pb_read_en && pb_chipselect[3]) pb_read_data[63:48] <= 16'h3333;
  end

  always @(negedge clock) begin
    if (cpu_ack) ack_cnt++;
    if (pb_write_en || pb_read_en) strobe_cnt++;
    if (|pb_chipselect) cs_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic snap();
    snap_ack    = ack_cnt;
    snap_strobe = strobe_cnt;
    snap_cs     = cs_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; pb_irq = '0;
    tick(); tick();
    check_eq("rst_ack",   32'(cpu_ack), 32'd0);
    check_eq("rst_cs",    32'(pb_chipselect), 32'd0);
    check_eq("rst_rdata", 32'(cpu_rdata), 32'd0);
    check_eq("rst_irq",   32'(cpu_irq), 32'd0);
    reset = 1'b0;
    tick();

    // Write 16'h00F0 to FF06 (periph 1, reg 2).
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFF06; cpu_wdata = 16'h00F0;
    tick();
    cpu_req = 1'b0;
    check_eq("wr_cs",     32'(pb_chipselect), 32'h2);
    check_eq("wr_addr",   32'(pb_addr), 32'd2);
    check_eq("wr_wen",    32'(pb_write_en), 32'd1);
    check_eq("wr_ren",    32'(pb_read_en), 32'd0);
    check_eq("wr_wdata",  32'(pb_write_data), 32'h00F0);
    check_eq("wr_ack_p1", 32'(cpu_ack), 32'd0);
    tick();
    check_eq("wr_ack_p2", 32'(cpu_ack), 32'd1);
    check_eq("wr_err",    32'(cpu_err), 32'd0);
    check_eq("wr_wen_off", 32'(pb_write_en), 32'd0);
    check_eq("wr_hold_wdata", 32'(pb_write_data), 32'h00F0);
    tick();
    check_eq("wr_ack_drop", 32'(cpu_ack), 32'd0);

    // Read FF00 (periph 0, reg 0).
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFF00;
    tick();
    cpu_req = 1'b0;
    check_eq("rd_ren",  32'(pb_read_en), 32'd1);
    check_eq("rd_wen",  32'(pb_write_en), 32'd0);
    check_eq("rd_cs",   32'(pb_chipselect), 32'h1);
    tick();
    check_eq("rd_ren_off", 32'(pb_read_en), 32'd0);
    check_eq("rd_ack_p2",  32'(cpu_ack), 32'd0);
    tick();
    check_eq("rd_ack_p3",  32'(cpu_ack), 32'd1);
    check_eq("rd_err",     32'(cpu_err), 32'd0);
    check_eq("rd_data",    32'(cpu_rdata), 32'hA5A5);
    tick();

    // A write afterwards leaves the read result in place.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFF04; cpu_wdata = 16'h1234;
    tick();
    cpu_req = 1'b0;
    tick();
    check_eq("wr2_ack",   32'(cpu_ack), 32'd1);
    check_eq("rd_hold",   32'(cpu_rdata), 32'hA5A5);
    tick();

    // Decode errors: index 5 inside the window, then outside the window.
    snap();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFF14;
    tick();
    cpu_req = 1'b0;
    check_eq("err1_ack",   32'(cpu_ack), 32'd1);
    check_eq("err1_err",   32'(cpu_err), 32'd1);
    check_eq("err1_rdata", 32'(cpu_rdata), 32'hA5A5);
    tick();
    check_eq("err1_ack_drop", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b1; cpu_addr = 16'h1200;
    tick();
    cpu_req = 1'b0;
    check_eq("err2_ack",   32'(cpu_ack), 32'd1);
    check_eq("err2_err",   32'(cpu_err), 32'd1);
    check_eq("err2_rdata", 32'(cpu_rdata), 32'hA5A5);
    tick();
    check_eq("err_no_strobe", 32'(strobe_cnt - snap_strobe), 32'd0);
    check_eq("err_no_cs",     32'(cs_cnt - snap_cs), 32'd0);

    // cpu_req held high for 10 cycles of writes: ack every 3 cycles.
    snap();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFF0C; cpu_wdata = 16'hBEEF;
    for (int i = 0; i < 10; i++) tick();
    cpu_req = 1'b0;
    check_eq("b2b_acks",    32'(ack_cnt - snap_ack), 32'd3);
    check_eq("b2b_strobes", 32'(strobe_cnt - snap_strobe), 32'd3);
    tick(); tick(); tick();

    // Reset during RDWAIT aborts the read with no ack.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFF03;
    tick();
    cpu_req = 1'b0;
    check_eq("abort_addr", 32'(pb_addr), 32'd3);
    tick();
    reset = 1'b1;
    snap();
    tick();
    reset = 1'b0;
    check_eq("abort_ack",   32'(cpu_ack), 32'd0);
    check_eq("abort_cs",    32'(pb_chipselect), 32'd0);
    check_eq("abort_ren",   32'(pb_read_en), 32'd0);
    check_eq("abort_paddr", 32'(pb_addr), 32'd0);
    check_eq("abort_wdata", 32'(pb_write_data), 32'd0);
    check_eq("abort_rdata", 32'(cpu_rdata), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("abort_no_ack", 32'(ack_cnt - snap_ack), 32'd0);

    // Interrupt aggregation.
    pb_irq = 4'b0100;
    check_eq("irq_pre", 32'(cpu_irq), 32'd0);
    tick();
    check_eq("irq_set", 32'(cpu_irq), 32'd1);
`ifdef PERIBUS_IRQ_ID_EN
    check_eq("irq_id2", 32'(irq_id), 32'd2);
    pb_irq = 4'b1010;
    tick();
    check_eq("irq_id1", 32'(irq_id), 32'd1);
    snap();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFF1C;
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
    check_eq("idreg_ack",    32'(cpu_ack), 32'd1);
    check_eq("idreg_err",    32'(cpu_err), 32'd0);
    check_eq("idreg_data",   32'(cpu_rdata), 32'd1);
    check_eq("idreg_no_stb", 32'(strobe_cnt - snap_strobe), 32'd0);
    tick();
`endif
    pb_irq = 4'b0000;
    tick();
    check_eq("irq_clr", 32'(cpu_irq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
